// File: rtl/alu_cmd_sequencer.sv
// Command front-end for a combinational ALU: registers operands, waits a settle time,
// then captures the result (with divide-by-zero override) into a fall-through response FIFO.
module alu_cmd_sequencer #(
   parameter int unsigned N      = 4,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [N-1:0]     cmd_a,
   input  logic [N-1:0]     cmd_b,
   output logic [N-1:0]     alu_operand1,
   output logic [N-1:0]     alu_operand2,
   output logic [N-1:0]     alu_operation,
   input  logic [2*N-1:0]   alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [2*N-1:0]   rsp_data,
   output logic [3:0]       rsp_op,
   output logic             rsp_dz,
   output logic             busy,
   output logic [15:0]      op_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [3:0]  OpDiv = 4'b0011;

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [N-1:0]    opa_q, opa_d, opb_q, opb_d;
   logic [3:0]      op_q, op_d;
   logic [15:0]     op_count_q, op_count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2*N-1:0]  data_mem_q [DEPTH];
   logic [2*N-1:0]  data_mem_d [DEPTH];
   logic [3:0]      op_mem_q [DEPTH];
   logic [3:0]      op_mem_d [DEPTH];
   logic            dz_mem_q [DEPTH];
   logic            dz_mem_d [DEPTH];

   logic            accept, push, pop, dz;
   logic [2*N-1:0]  push_data;

   assign cmd_ready = rst_n && (state_q == StIdle) && (count_q < CW'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;
   assign push      = (state_q == StWait) && (cnt_q == 4'd0);
   assign pop       = rsp_ready && (count_q != '0);
   assign dz        = (op_q == OpDiv) && (opb_q == '0);
   assign push_data = dz ? {(2*N){1'b1}} : alu_result;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      op_d       = op_q;
      op_count_d = op_count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_mem_d = data_mem_q;
      op_mem_d   = op_mem_q;
      dz_mem_d   = dz_mem_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               opa_d   = cmd_a;
               opb_d   = cmd_b;
               op_d    = cmd_op;
               cnt_d   = 4'(SETTLE - 1);
               state_d = StWait;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               op_count_d = op_count_q + 16'd1;
               state_d    = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Accept is gated on free space, so a push always has a slot.
      if (push) begin
         data_mem_d[wr_ptr_q] = push_data;
         op_mem_d[wr_ptr_q]   = op_q;
         dz_mem_d[wr_ptr_q]   = dz;
         wr_ptr_d             = AW'(wr_ptr_q + 1'b1);
      end
      if (pop) rd_ptr_d = AW'(rd_ptr_q + 1'b1);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         op_q       <= '0;
         op_count_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_mem_q[i] <= '0;
            op_mem_q[i]   <= '0;
            dz_mem_q[i]   <= 1'b0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         op_q       <= op_d;
         op_count_q <= op_count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_mem_q <= data_mem_d;
         op_mem_q   <= op_mem_d;
         dz_mem_q   <= dz_mem_d;
      end
   end

   assign alu_operand1  = opa_q;
   assign alu_operand2  = opb_q;
   assign alu_operation = N'(op_q);
   assign busy          = (state_q == StWait);
   assign op_count      = op_count_q;
   assign rsp_valid     = (count_q != '0);
   // Head fields read as zero while empty so the reset/empty view is deterministic.
   assign rsp_data      = rsp_valid ? data_mem_q[rd_ptr_q] : '0;
   assign rsp_op        = rsp_valid ? op_mem_q[rd_ptr_q] : '0;
   assign rsp_dz        = rsp_valid ? dz_mem_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: a SETTLE=1 instance for function/back-pressure/reset,
// and a SETTLE=3 instance for settle timing. A small ALU model drives alu_result.
module tb_alu_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   int          n_checks = 0;
   int          n_fail   = 0;

   logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_dz, busy;
   logic [3:0]  cmd_op, rsp_op;
   logic [3:0]  cmd_a, cmd_b, alu_operand1, alu_operand2, alu_operation;
   logic [7:0]  alu_result, rsp_data;
   logic [15:0] op_count;

   logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_dz3, busy3;
   logic [3:0]  cmd_op3, rsp_op3;
   logic [3:0]  cmd_a3, cmd_b3, alu_operand1_3, alu_operand2_3, alu_operation3;
   logic [7:0]  alu_result3, rsp_data3;
   logic [15:0] op_count3;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
      case (op)
         4'd0:    return 8'(a) + 8'(b);
         4'd1:    return 8'(a) - 8'(b);
         4'd2:    return 8'(a) * 8'(b);
         4'd3:    return (b == 4'd0) ? 8'h00 : 8'(a / b);
         default: return 8'h00;
      endcase
   endfunction

   assign alu_result  = alu_model(alu_operation, alu_operand1, alu_operand2);
   assign alu_result3 = alu_model(alu_operation3, alu_operand1_3, alu_operand2_3);

   alu_cmd_sequencer #(.N(4), .SETTLE(1), .DEPTH(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
      .alu_operation(alu_operation), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_op(rsp_op), .rsp_dz(rsp_dz), .busy(busy), .op_count(op_count)
   );

   alu_cmd_sequencer #(.N(4), .SETTLE(3), .DEPTH(4)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
      .cmd_a(cmd_a3), .cmd_b(cmd_b3),
      .alu_operand1(alu_operand1_3), .alu_operand2(alu_operand2_3),
      .alu_operation(alu_operation3), .alu_result(alu_result3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
      .rsp_op(rsp_op3), .rsp_dz(rsp_dz3), .busy(busy3), .op_count(op_count3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input string tag, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b);
      int w = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && w < 20) begin
         tick();
         w++;
      end
      check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_rsp(input string tag, input logic [7:0] data, input logic [3:0] op,
                             input logic dz);
      int w = 0;
      while (!rsp_valid && w < 20) begin
         tick();
         w++;
      end
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_data"}, 32'(rsp_data), 32'(data));
      check({tag, "_op"}, 32'(rsp_op), 32'(op));
      check({tag, "_dz"}, 32'(rsp_dz), 32'(dz));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
      cmd_valid3 = 1'b0; cmd_op3 = '0; cmd_a3 = '0; cmd_b3 = '0; rsp_ready3 = 1'b0;
      #12;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_alu_op1", 32'(alu_operand1), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // ADD 3+5: accept at edge 0, result visible after edge 1
      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'd3; cmd_b = 4'd5;
      tick();
      cmd_valid = 1'b0;
      check("add_busy", 32'(busy), 32'd1);
      check("add_wait_ready", 32'(cmd_ready), 32'd0);
      check("add_alu_op1", 32'(alu_operand1), 32'd3);
      check("add_alu_op2", 32'(alu_operand2), 32'd5);
      check("add_no_rsp_yet", 32'(rsp_valid), 32'd0);
      tick();
      check("add_rsp_valid", 32'(rsp_valid), 32'd1);
      check("add_op_count", 32'(op_count), 32'd1);
      check("add_busy_done", 32'(busy), 32'd0);
      expect_rsp("add", 8'h08, 4'd0, 1'b0);
      check("add_empty", 32'(rsp_valid), 32'd0);
      check("alu_op1_held", 32'(alu_operand1), 32'd3);

      // SUB then MUL, queued, drained in order
      do_cmd("sub", 4'd1, 4'd2, 4'd5);
      do_cmd("mul", 4'd2, 4'd15, 4'd15);
      expect_rsp("sub", 8'hFD, 4'd1, 1'b0);
      expect_rsp("mul", 8'hE1, 4'd2, 1'b0);

      // Divide by zero override, then a normal divide
      do_cmd("dz", 4'd3, 4'd9, 4'd0);
      expect_rsp("dz", 8'hFF, 4'd3, 1'b1);
      do_cmd("div", 4'd3, 4'd9, 4'd2);
      expect_rsp("div", 8'h04, 4'd3, 1'b0);
      check("op_count_5", 32'(op_count), 32'd5);

      // Back-pressure: fill the FIFO, 5th command stalls until one pop
      for (int i = 1; i <= 4; i++) do_cmd("bp_fill", 4'd0, 4'(i), 4'd1);
      tick();
      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 4'd5; cmd_b = 4'd1;
      for (int i = 0; i < 3; i++) begin
         check("bp_full_ready", 32'(cmd_ready), 32'd0);
         check("bp_head_stable", 32'(rsp_data), 32'h02);
         tick();
      end
      check("bp_op_count", 32'(op_count), 32'd9);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_after_pop_ready", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      check("bp_5th_busy", 32'(busy), 32'd1);
      expect_rsp("bp2", 8'h03, 4'd0, 1'b0);
      expect_rsp("bp3", 8'h04, 4'd0, 1'b0);
      expect_rsp("bp4", 8'h05, 4'd0, 1'b0);
      expect_rsp("bp5", 8'h06, 4'd0, 1'b0);
      check("bp_drained", 32'(rsp_valid), 32'd0);
      check("op_count_10", 32'(op_count), 32'd10);

      // SETTLE=3 instance: hold for 3 cycles, capture at edge k+3
      check("s3_ready", 32'(cmd_ready3), 32'd1);
      cmd_valid3 = 1'b1; cmd_op3 = 4'd2; cmd_a3 = 4'd3; cmd_b3 = 4'd4;
      tick();
      cmd_valid3 = 1'b0; cmd_a3 = 4'd0; cmd_b3 = 4'd0;
      for (int i = 0; i < 3; i++) begin
         check("s3_busy", 32'(busy3), 32'd1);
         check("s3_wait_ready", 32'(cmd_ready3), 32'd0);
         check("s3_alu_op1", 32'(alu_operand1_3), 32'd3);
         check("s3_alu_op2", 32'(alu_operand2_3), 32'd4);
         check("s3_alu_opc", 32'(alu_operation3), 32'd2);
         check("s3_no_rsp", 32'(rsp_valid3), 32'd0);
         tick();
      end
      check("s3_busy_done", 32'(busy3), 32'd0);
      check("s3_rsp_valid", 32'(rsp_valid3), 32'd1);
      check("s3_rsp_data", 32'(rsp_data3), 32'h0C);
      check("s3_op_count", 32'(op_count3), 32'd1);
      check("s3_ready_again", 32'(cmd_ready3), 32'd1);

      // Reset mid-WAIT with two entries pending
      do_cmd("rst_a", 4'd0, 4'd1, 4'd1);
      do_cmd("rst_b", 4'd0, 4'd2, 4'd2);
      do_cmd("rst_c", 4'd0, 4'd3, 4'd3);
      check("rst_pre_busy", 32'(busy), 32'd1);
      check("rst_pre_valid", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_count", 32'(op_count), 32'd0);
      check("rst_mid_ready", 32'(cmd_ready), 32'd0);
      check("rst_mid_alu_op1", 32'(alu_operand1), 32'd0);
      check("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_mid_valid3", 32'(rsp_valid3), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_count", 32'(op_count), 32'd0);
      do_cmd("post", 4'd0, 4'd7, 4'd7);
      expect_rsp("post", 8'h0E, 4'd0, 1'b0);
      check("post_op_count", 32'(op_count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
